// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and helpers for the decoder_scan block:
//   state_e     : controller state (OFF, DIRECT, SCAN)
//   MODE_DIRECT : mode input value selecting direct decode
//   MODE_SCAN   : mode input value selecting autonomous scan
//   onehot(n)   : width of the one-hot output for an n-bit select (2^n)
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Output width of an n-bit one-hot decoder.
  function automatic int unsigned onehot(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage : decoder_pkg

// File: rtl/decoder_n.sv
// -----------------------------------------------------------------------------
// decoder_n
// Combinational enable-gated N-to-2^N one-hot decoder.
// Ports:
//   E   in  1      enable; 0 forces Out to all zeros
//   In  in  N      select index
//   Out out 2^N    one-hot vector with bit In set (when E = 1)
// -----------------------------------------------------------------------------
module decoder_n
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                   E,
  input  logic [N-1:0]           In,
  output logic [onehot(N)-1:0]   Out
);

  // Set exactly one bit when enabled, otherwise drive zeros.
  always_comb begin
    Out = '0;
    if (E) begin
      Out[In] = 1'b1;
    end else begin
      Out = '0;
    end
  end

endmodule : decoder_n

// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
// One-hot decoder with registered output, valid/ready select input and an
// autonomous scan mode that walks the one-hot output through every position
// with a programmable dwell time.
// Ports:
//   clk       in   1        rising-edge clock
//   rst_n     in   1        synchronous reset, active low
//   E         in   1        enable; 0 clears Out on the next edge
//   mode      in   1        0 = DIRECT, 1 = SCAN
//   in_valid  in   1        select code valid (DIRECT only)
//   In        in   N        select code
//   in_ready  out  1        combinational: E & ~mode & (state == DIRECT)
//   dwell     in   DWELL_W  extra cycles each scan position is held
//   Out       out  2^N      registered one-hot output, or all zeros
//   out_idx   out  N        registered index of the current/last position
//   wrap      out  1        registered pulse on the scan step 2^N-1 -> 0
// -----------------------------------------------------------------------------
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   E,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic [N-1:0]           In,
  output logic                   in_ready,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [onehot(N)-1:0]   Out,
  output logic [N-1:0]           out_idx,
  output logic                   wrap
);

  localparam int              W       = onehot(N);
  localparam logic [N-1:0]    IDX_ONE = N'(1);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_e               r_state;
  logic [W-1:0]         r_out;
  logic [N-1:0]         r_idx;
  logic                 r_wrap;
  logic [DWELL_W-1:0]   r_cnt;

  state_e               w_next_state;
  logic [N-1:0]         w_idx_nxt;
  logic [N-1:0]         w_idx_inc;
  logic [N-1:0]         w_dec_idx;
  logic [DWELL_W-1:0]   w_cnt_nxt;
  logic                 w_wrap_nxt;
  logic                 w_load;
  logic                 w_xfer;
  logic [W-1:0]         w_dec;
  logic [W-1:0]         w_out_nxt;

  assign in_ready  = E & (mode == MODE_DIRECT) & (r_state == DIRECT);
  assign w_xfer    = in_valid & in_ready;
  assign w_idx_inc = r_idx + IDX_ONE;

  // The decoder is gated by E, so a disabled cycle decodes to all zeros.
  decoder_n #(
    .N (N)
  ) u_decoder_n (
    .E   (E),
    .In  (w_dec_idx),
    .Out (w_dec)
  );

  // Next-state selection: E dominates, then mode picks DIRECT or SCAN.
  always_comb begin
    w_next_state = r_state;
    if (!E) begin
      w_next_state = OFF;
    end else if (mode == MODE_SCAN) begin
      w_next_state = SCAN;
    end else begin
      w_next_state = DIRECT;
    end
  end

  // Datapath next values: which index to decode, counter and wrap updates.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_load     = 1'b0;
    w_dec_idx  = r_idx;
    if (!E) begin
      // Disabled: Out clears through the gated decoder, index is retained.
      w_cnt_nxt = '0;
    end else if (mode == MODE_DIRECT) begin
      // Partial dwell counts are discarded when leaving scan.
      w_cnt_nxt = '0;
      if (w_xfer) begin
        w_load    = 1'b1;
        w_dec_idx = In;
        w_idx_nxt = In;
      end else begin
        w_load    = 1'b0;
      end
    end else begin
      case (r_state)
        SCAN: begin
          // >= rather than == so a lowered dwell advances immediately.
          if (r_cnt >= dwell) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = w_idx_inc;
            w_dec_idx  = w_idx_inc;
            w_load     = 1'b1;
            w_wrap_nxt = (r_idx == {N{1'b1}});
          end else begin
            w_cnt_nxt  = r_cnt + CNT_ONE;
          end
        end
        OFF, DIRECT: begin
          // Scan entry: show the current position on the first SCAN cycle.
          w_cnt_nxt = '0;
          w_load    = 1'b1;
          w_dec_idx = r_idx;
        end
        default: begin
          w_cnt_nxt = '0;
          w_load    = 1'b0;
        end
      endcase
    end
  end

  // Out reloads on decode events and clears whenever E is low.
  always_comb begin
    w_out_nxt = r_out;
    if (w_load || !E) begin
      w_out_nxt = w_dec;
    end else begin
      w_out_nxt = r_out;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_out   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_out   <= w_out_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign Out     = r_out;
  assign out_idx = r_idx;
  assign wrap    = r_wrap;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic       mode;
  logic       in_valid;
  logic [2:0] In;
  logic       in_ready;
  logic [7:0] dwell;
  logic [7:0] Out;
  logic [2:0] out_idx;
  logic       wrap;

  int n_vec;
  int n_err;

  // Scoreboard entries: {Out[7:0], out_idx[2:0], wrap}
  logic [11:0] exp_q[$];

  decoder_scan #(
    .N       (3),
    .DWELL_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E        (E),
    .mode     (mode),
    .in_valid (in_valid),
    .In       (In),
    .in_ready (in_ready),
    .dwell    (dwell),
    .Out      (Out),
    .out_idx  (out_idx),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, check in_ready before the edge, push the
  // expected registered result, then pop and compare it after the edge.
  task automatic step(input string tag, input logic e, input logic m,
                      input logic v, input logic [2:0] in_v,
                      input logic [7:0] dw, input logic er,
                      input logic [7:0] eo, input logic [2:0] ei,
                      input logic ew);
    logic [11:0] ex;
    E        = e;
    mode     = m;
    in_valid = v;
    In       = in_v;
    dwell    = dw;
    #1;
    chk({tag, ".rdy"}, {7'd0, in_ready}, {7'd0, er});
    exp_q.push_back({eo, ei, ew});
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    chk({tag, ".out"},  Out,                 ex[11:4]);
    chk({tag, ".idx"},  {5'd0, out_idx},     {5'd0, ex[3:1]});
    chk({tag, ".wrap"}, {7'd0, wrap},        {7'd0, ex[0]});
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    E        = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    In       = 3'd0;
    dwell    = 8'd0;

    // 1. Reset, then a DIRECT transfer of code 5
    step("rst0", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 3'd0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 1'b0, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step("off2dir", 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 1'b0, 8'h00, 3'd0, 1'b0);
    step("dir5",    1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 1'b1, 8'h20, 3'd5, 1'b0);

    // 2. Back-to-back transfers, then in_valid with E low
    step("dir0",  1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b1, 8'h01, 3'd0, 1'b0);
    step("dir7",  1'b1, 1'b0, 1'b1, 3'd7, 8'd0, 1'b1, 8'h80, 3'd7, 1'b0);
    step("dir3",  1'b1, 1'b0, 1'b1, 3'd3, 8'd0, 1'b1, 8'h08, 3'd3, 1'b0);
    step("eoff0", 1'b0, 1'b0, 1'b1, 3'd5, 8'd0, 1'b0, 8'h00, 3'd3, 1'b0);
    step("eoff1", 1'b0, 1'b0, 1'b1, 3'd6, 8'd0, 1'b0, 8'h00, 3'd3, 1'b0);

    // 3. Scan with dwell 0 starting from position 6
    step("reen",  1'b1, 1'b0, 1'b1, 3'd6, 8'd0, 1'b0, 8'h00, 3'd3, 1'b0);
    step("dir6",  1'b1, 1'b0, 1'b1, 3'd6, 8'd0, 1'b1, 8'h40, 3'd6, 1'b0);
    step("sc0e",  1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'h40, 3'd6, 1'b0);
    step("sc0a",  1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'h80, 3'd7, 1'b0);
    step("sc0b",  1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'h01, 3'd0, 1'b1);
    step("sc0c",  1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'h02, 3'd1, 1'b0);
    step("sc0d",  1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'h04, 3'd2, 1'b0);

    // 4. Dwell 2: full sweep of 24 cycles, 3 cycles per position
    for (int k = 1; k <= 24; k++) begin
      int          pos;
      logic [7:0]  one;
      logic        w;
      pos = (2 + k / 3) % 8;
      one = 8'd1;
      w   = ((k % 3) == 0) && (pos == 0);
      step($sformatf("sc2_%0d", k), 1'b1, 1'b1, 1'b0, 3'd0, 8'd2, 1'b0,
           one << pos, pos[2:0], w);
    end

    // Dwell 5 run up to count 4, then lowered to 1: advance at once
    for (int k = 1; k <= 4; k++) begin
      step($sformatf("sc5_%0d", k), 1'b1, 1'b1, 1'b0, 3'd0, 8'd5, 1'b0,
           8'h04, 3'd2, 1'b0);
    end
    step("dwlow", 1'b1, 1'b1, 1'b0, 3'd0, 8'd1, 1'b0, 8'h08, 3'd3, 1'b0);

    // 5. SCAN -> DIRECT at position 3 holds 08
    step("s2d0",  1'b1, 1'b0, 1'b0, 3'd0, 8'd1, 1'b0, 8'h08, 3'd3, 1'b0);
    step("s2d1",  1'b1, 1'b0, 1'b0, 3'd0, 8'd1, 1'b1, 8'h08, 3'd3, 1'b0);
    // Back to SCAN, drop E mid-dwell, then re-enter with a full dwell
    step("d2s",   1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h08, 3'd3, 1'b0);
    step("mid",   1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h08, 3'd3, 1'b0);
    step("edrop", 1'b0, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h00, 3'd3, 1'b0);
    step("resc",  1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h08, 3'd3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("hold3_%0d", k), 1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0,
           8'h08, 3'd3, 1'b0);
    end
    step("adv4",  1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h10, 3'd4, 1'b0);

    // 6. Reset mid-scan at position 4, then state follows E/mode
    rst_n = 1'b0;
    step("rstsc", 1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step("post0", 1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h01, 3'd0, 1'b0);
    step("post1", 1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0, 8'h01, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decoder_scan

// File: doc/decoder_scan.md
# decoder_scan

Parametrised N-to-2^N one-hot decoder with registered output, a valid/ready select input and an autonomous scan mode. In DIRECT mode it decodes each accepted select code; in SCAN mode it walks the one-hot output through all 2^N positions with a programmable dwell time. It sits between control logic and multiplexed loads such as display digit enables and bank selects, and supersedes the fixed-width enable-gated decoders.

## Interface
- N, default 3: select width; output width is 2^N (N ≥ 1).
- DWELL_W, default 8: width of the dwell-time field.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- E  in  1  enable; 0 forces the output to zero.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- in_valid  in  1  select code valid (DIRECT only).
- In  in  N  select code.
- in_ready  out  1  combinational; equals E & ~mode & (state == DIRECT).
- dwell  in  DWELL_W  extra cycles each SCAN position is held (0 = advance every cycle).
- Out  out  2^N  registered one-hot output, or all zeros.
- out_idx  out  N  registered index of the current/last position.
- wrap  out  1  registered one-cycle pulse on the SCAN step from 2^N−1 to 0.

## Operation
- Reset (rst_n = 0 at a clock edge): state = OFF, Out = 0, out_idx = 0, wrap = 0, dwell counter = 0. Reset takes priority over all other inputs.
- States and transitions (evaluated every cycle; E has the highest priority):
  - E = 0: next state is OFF. Out = 0 and the dwell counter clears. out_idx is retained.
  - E = 1, mode = 0: next state is DIRECT. E = 1, mode = 1: next state is SCAN.
- OFF: Out = 0, wrap = 0, in_ready = 0.
- DIRECT:
  - A transfer occurs when in_valid & in_ready. On that edge Out ← 1 << In and out_idx ← In.
  - With no transfer, Out and out_idx hold.
  - Entering DIRECT from OFF: Out stays 0 until the first transfer.
  - Entering DIRECT from SCAN: Out holds the last scan position until the first transfer.
  - in_valid while in_ready = 0 is ignored, with no side effects.
- SCAN:
  - Out = 1 << out_idx. The dwell counter increments each cycle.
  - When the counter equals dwell: the counter ← 0 and out_idx ← out_idx + 1 mod 2^N.
  - wrap = 1 for exactly the cycle in which Out first shows position 0 after position 2^N−1.
  - Entering SCAN from DIRECT or OFF: scanning starts at the current out_idx with the counter cleared. Out shows that position on the first SCAN cycle. wrap is not asserted on entry.
  - dwell is sampled every cycle. If dwell is lowered below the current count, the comparison `count ≥ dwell` advances on the next cycle, so the counter never runs to overflow.
- Mode change mid-dwell discards the partial count.
- No arithmetic overflow is possible: out_idx wraps naturally at N bits, and the counter is bounded by dwell.

## Timing
- DIRECT latency: 1 cycle from the accepting edge to Out/out_idx. Back-to-back transfers are accepted every cycle.
- SCAN period per position: dwell + 1 cycles. Full sweep: 2^N × (dwell + 1) cycles.
- State update: 1 cycle after E/mode changes. in_ready follows E/mode combinationally in the same cycle, but only asserts once state == DIRECT.
- E falling: Out = 0 on the next edge. E rising: first decode/scan output appears 1 cycle after state leaves OFF.
- All outputs except in_ready are registered, with no combinational input→output path.

## Structure
- Package decoder_pkg holds:
  - the state enum (OFF, DIRECT, SCAN);
  - the mode constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1;
  - the function onehot(N) returning 2^N.
- Sub-module decoder_n (parametrised N, combinational E-gated shift decode, Out = E ? 1 << In : 0) produces the one-hot vector from the selected index. decoder_scan registers its output.

## Test plan
1. Reset then DIRECT, N=3:
   - Stimulus: rst_n low 2 cycles; then E=1, mode=0, In=5, in_valid=1.
   - Required response: Out = 8'h00 during and after reset until the transfer. One cycle after acceptance, Out = 8'h20 and out_idx = 5.
2. Back-to-back DIRECT:
   - Stimulus: In = 0, 7, 3 on consecutive accepted cycles.
   - Required response: Out = 01, 80, 08 on the following consecutive cycles. in_valid with E=0 leaves Out = 0 and in_ready = 0.
3. SCAN, dwell=0:
   - Stimulus: start from out_idx=6.
   - Required response: Out sequence 40, 80, 01, 02, … one position per cycle. wrap high only in the cycle Out = 01.
4. SCAN, dwell=2:
   - Required response: each position held exactly 3 cycles, full sweep 24 cycles.
   - Stimulus: change dwell from 5 to 1 at count 4.
   - Required response: advance on the next cycle.
5. Mode/enable interaction:
   - Stimulus: switch SCAN→DIRECT at position 3.
   - Required response: Out holds 08 until the next transfer.
   - Stimulus: drop E mid-dwell.
   - Required response: Out = 0 next cycle.
   - Stimulus: re-enter SCAN.
   - Required response: resumes at position 3 with a full dwell.
6. Reset mid-SCAN:
   - Stimulus: rst_n low for 1 cycle at position 4.
   - Required response: Out = 0, out_idx = 0, wrap = 0 next cycle. Then state follows E/mode.
